fifo_reader_stream: RTL and testbench

FIFO_READER_STREAM -- requirements
Module: fifo_reader_stream

---
 rtl/fifo_reader_pkg.sv | 28 ++
 rtl/fifo_reader_skid_buf.sv | 67 ++++++
 rtl/fifo_reader_stream.sv | 94 +++++++++
 tb/tb_fifo_reader_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg
// Shared constants and the credit helper for fifo_reader_stream.
//   BUF_DEPTH  : entries in the output ring buffer
//   BUF_CNT_W  : width of the occupancy count (holds 0..BUF_DEPTH)
//   XFER_CNT_W : width of the accepted-word counter
//   has_credit : true when a new FIFO read still fits in the buffer
package fifo_reader_pkg;

    localparam int BUF_DEPTH  = 2;
    localparam int BUF_CNT_W  = 2;
    localparam int XFER_CNT_W = 32;

    typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

    // Words already committed to the buffer once this cycle settles:
    // held words plus a word still on its way from the FIFO, minus the
    // word leaving this cycle. A read may start only if room remains.
    function automatic logic has_credit(input buf_cnt_t cnt,
                                        input logic     inflight,
                                        input logic     pop);
        logic [BUF_CNT_W:0] committed;
        committed = {1'b0, cnt}
                  + {{BUF_CNT_W{1'b0}}, inflight}
                  - {{BUF_CNT_W{1'b0}}, pop};
        return committed < (BUF_CNT_W + 1)'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_reader_skid_buf.sv
// fifo_reader_skid_buf
// Two-entry ring buffer with 1-bit write/read pointers and an occupancy count.
// The head entry is visible combinationally; all state clears on reset.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the write pointer
//   push_data  : word to store
//   pop        : retire the head entry
//   head_data  : entry at the read pointer
//   buf_cnt    : words held (0..2)
module fifo_reader_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH_DATA = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH_DATA-1:0] push_data,
    input  logic                  pop,
    output logic [WIDTH_DATA-1:0] head_data,
    output buf_cnt_t              buf_cnt
);

    logic [WIDTH_DATA-1:0] mem_reg [BUF_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    buf_cnt_t              cnt_reg;

    // Storage is cleared too so the head reads as zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // A push and pop in the same cycle advance both pointers and leave
    // the count alone. When full, the slot written is the one being
    // popped, so a same-cycle refill is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            unique case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + buf_cnt_t'(1);
                2'b01:   cnt_reg <= cnt_reg - buf_cnt_t'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign buf_cnt   = cnt_reg;

endmodule

// File: rtl/fifo_reader_stream.sv
// fifo_reader_stream
// Drains a FIFO read port into a valid/ready stream through a 2-entry buffer,
// sustaining one word per cycle in either FIFO read mode.
// Parameters:
//   WIDTH_DATA : data word width
//   SHOW_AHEAD : 1 = fifo_rdata valid while not empty (push with fifo_ren),
//                0 = fifo_rdata valid the cycle after fifo_ren
// Ports:
//   rdclock, rd_rst         : clock, asynchronous active-high reset
//   fifo_empty, fifo_rdata  : FIFO status and read data
//   fifo_ren                : FIFO read enable (combinational)
//   m_valid, m_data, m_ready: output stream
//   buf_cnt                 : words held in the buffer
//   xfer_cnt                : accepted-word count
// Optional feature macro: FIFO_READER_STREAM_XFER_CNT_EN builds the xfer_cnt
// counter; without it xfer_cnt is tied to zero.
module fifo_reader_stream
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH_DATA = 36,
    parameter int SHOW_AHEAD = 1
) (
    input  logic                  rdclock,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    input  logic [WIDTH_DATA-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  m_valid,
    output logic [WIDTH_DATA-1:0] m_data,
    input  logic                  m_ready,
    output logic [BUF_CNT_W-1:0]  buf_cnt,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    buf_cnt_t cnt;
    logic     inflight;
    logic     push;
    logic     pop;

    assign m_valid = (cnt != '0);
    assign pop     = m_valid && m_ready;

    // Reset is folded in so no read escapes while the buffer is held clear.
    assign fifo_ren = !rd_rst && !fifo_empty && has_credit(cnt, inflight, pop);

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Data is already on fifo_rdata: capture it with the read.
            assign inflight = 1'b0;
            assign push     = fifo_ren;
        end else begin : g_registered
            // Data appears one cycle after the read; remember it is coming.
            logic inflight_reg;
            always_ff @(posedge rdclock or posedge rd_rst) begin
                if (rd_rst) begin
                    inflight_reg <= 1'b0;
                end else begin
                    inflight_reg <= fifo_ren;
                end
            end
            assign inflight = inflight_reg;
            assign push     = inflight_reg;
        end
    endgenerate

    fifo_reader_skid_buf #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_skid_buf (
        .clk       (rdclock),
        .rst       (rd_rst),
        .push      (push),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (m_data),
        .buf_cnt   (cnt)
    );

    assign buf_cnt = cnt;

`ifdef FIFO_READER_STREAM_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_reg;
    always_ff @(posedge rdclock or posedge rd_rst) begin
        if (rd_rst) begin
            xfer_cnt_reg <= '0;
        end else if (pop) begin
            xfer_cnt_reg <= xfer_cnt_reg + XFER_CNT_W'(1);
        end
    end
    assign xfer_cnt = xfer_cnt_reg;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_reader_stream.sv
// tb_fifo_reader_stream
// Drives two instances side by side: u_a with SHOW_AHEAD=1 and u_b with
// SHOW_AHEAD=0, each fed by a small behavioural FIFO. Per-cycle vector tables
// hold the expected outputs; reset and counter wrap are hand-written sequences.
module tb_fifo_reader_stream;

    localparam int W = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst, b_rst;
    logic          a_empty, b_empty;
    logic [W-1:0]  a_rdata;
    logic [W-1:0]  b_rdata = '0;
    logic          a_ren, b_ren;
    logic          a_valid, b_valid;
    logic [W-1:0]  a_data, b_data;
    logic          a_ready, b_ready;
    logic [1:0]    a_cnt, b_cnt;
    logic [31:0]   a_xfer, b_xfer;

    // Behavioural FIFOs: monotonic indices, 16-deep storage.
    logic [W-1:0] a_mem [0:15];
    logic [W-1:0] b_mem [0:15];
    int a_rd = 0, a_wr = 0;
    int b_rd = 0, b_wr = 0;

    assign a_empty = (a_rd == a_wr);
    assign b_empty = (b_rd == b_wr);
    assign a_rdata = a_mem[a_rd[3:0]];

    always @(posedge clk) if (a_ren) a_rd <= a_rd + 1;
    always @(posedge clk) begin
        if (b_ren) begin
            b_rdata <= b_mem[b_rd[3:0]];
            b_rd    <= b_rd + 1;
        end
    end

    fifo_reader_stream #(.WIDTH_DATA(W), .SHOW_AHEAD(1)) u_a (
        .rdclock(clk), .rd_rst(a_rst), .fifo_empty(a_empty), .fifo_rdata(a_rdata),
        .fifo_ren(a_ren), .m_valid(a_valid), .m_data(a_data), .m_ready(a_ready),
        .buf_cnt(a_cnt), .xfer_cnt(a_xfer));

    fifo_reader_stream #(.WIDTH_DATA(W), .SHOW_AHEAD(0)) u_b (
        .rdclock(clk), .rd_rst(b_rst), .fifo_empty(b_empty), .fifo_rdata(b_rdata),
        .fifo_ren(b_ren), .m_valid(b_valid), .m_data(b_data), .m_ready(b_ready),
        .buf_cnt(b_cnt), .xfer_cnt(b_xfer));

    typedef struct {
        int           ld;     // words loaded into the FIFO before this cycle
        logic [W-1:0] base;   // first loaded word, then base+1, ...
        logic         ready;
        logic         ren;
        logic         valid;
        logic [W-1:0] data;   // compared only when valid is expected
        logic [1:0]   cnt;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_x [2];
    vec_t        tab_a [$];
    vec_t        tab_b [$];

    function automatic vec_t mk(input int ld, input logic [W-1:0] base, input logic r,
                                input logic ren, input logic val,
                                input logic [W-1:0] d, input logic [1:0] c);
        vec_t v;
        v.ld = ld; v.base = base; v.ready = r;
        v.ren = ren; v.valid = val; v.data = d; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic load(input int w, input logic [W-1:0] d);
        if (w == 0) begin
            a_mem[a_wr[3:0]] = d;
            a_wr++;
        end else begin
            b_mem[b_wr[3:0]] = d;
            b_wr++;
        end
    endtask

    task automatic sample(input int w, output logic ren, output logic val,
                          output logic [W-1:0] dat, output logic [1:0] cnt,
                          output logic [31:0] xf);
        if (w == 0) begin
            ren = a_ren; val = a_valid; dat = a_data; cnt = a_cnt; xf = a_xfer;
        end else begin
            ren = b_ren; val = b_valid; dat = b_data; cnt = b_cnt; xf = b_xfer;
        end
    endtask

    // Called at a falling edge: load, drive, compare, then advance one cycle.
    task automatic step(input int w, input vec_t v, input string nm);
        logic ren, val;
        logic [W-1:0] dat;
        logic [1:0] cnt;
        logic [31:0] xf;
        for (int k = 0; k < v.ld; k++) load(w, v.base + W'(k));
        if (w == 0) a_ready = v.ready; else b_ready = v.ready;
        #1;
        sample(w, ren, val, dat, cnt, xf);
        chk({nm, ".ren"},   64'(ren), 64'(v.ren));
        chk({nm, ".valid"}, 64'(val), 64'(v.valid));
        chk({nm, ".cnt"},   64'(cnt), 64'(v.cnt));
        if (v.valid) chk({nm, ".data"}, 64'(dat), 64'(v.data));
        chk({nm, ".xfer"},  64'(xf),  64'(exp_x[w]));
`ifdef FIFO_READER_STREAM_XFER_CNT_EN
        if (v.valid && v.ready) exp_x[w] = exp_x[w] + 32'd1;
`endif
        $display("step %-6s dut=%0d ready=%0b ren=%0b valid=%0b data=%h cnt=%0d xfer=%0d",
                 nm, w, v.ready, ren, val, dat, cnt, xf);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expects every output at its reset value right now.
    task automatic chk_zero(input int w, input string nm);
        logic ren, val;
        logic [W-1:0] dat;
        logic [1:0] cnt;
        logic [31:0] xf;
        sample(w, ren, val, dat, cnt, xf);
        chk({nm, ".ren"},   64'(ren), 64'd0);
        chk({nm, ".valid"}, 64'(val), 64'd0);
        chk({nm, ".data"},  64'(dat), 64'd0);
        chk({nm, ".cnt"},   64'(cnt), 64'd0);
        chk({nm, ".xfer"},  64'(xf),  64'd0);
        $display("reset  %-6s dut=%0d ren=%0b valid=%0b data=%h cnt=%0d xfer=%0d",
                 nm, w, ren, val, dat, cnt, xf);
    endtask

    initial begin
        exp_x[0] = '0;
        exp_x[1] = '0;

        // SHOW_AHEAD=1: 1..4 streamed back to back
        tab_a.push_back(mk(4, 36'h1, 1, 1, 0, 36'h0, 2'd0));
        tab_a.push_back(mk(0, 36'h0, 1, 1, 1, 36'h1, 2'd1));
        tab_a.push_back(mk(0, 36'h0, 1, 1, 1, 36'h2, 2'd1));
        tab_a.push_back(mk(0, 36'h0, 1, 1, 1, 36'h3, 2'd1));
        tab_a.push_back(mk(0, 36'h0, 1, 0, 1, 36'h4, 2'd1));
        tab_a.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));
        // backpressure for 5 cycles, then drain at full rate
        tab_a.push_back(mk(5, 36'h11, 0, 1, 0, 36'h0,  2'd0));
        tab_a.push_back(mk(0, 36'h0,  0, 1, 1, 36'h11, 2'd1));
        tab_a.push_back(mk(0, 36'h0,  0, 0, 1, 36'h11, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  0, 0, 1, 36'h11, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  0, 0, 1, 36'h11, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  1, 1, 1, 36'h11, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  1, 1, 1, 36'h12, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  1, 1, 1, 36'h13, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  1, 0, 1, 36'h14, 2'd2));
        tab_a.push_back(mk(0, 36'h0,  1, 0, 1, 36'h15, 2'd1));
        tab_a.push_back(mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0));
        // FIFO empty throughout
        tab_a.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));
        tab_a.push_back(mk(0, 36'h0, 0, 0, 0, 36'h0, 2'd0));
        tab_a.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));

        // SHOW_AHEAD=0: first valid two cycles after the first read
        tab_b.push_back(mk(4, 36'h1, 1, 1, 0, 36'h0, 2'd0));
        tab_b.push_back(mk(0, 36'h0, 1, 1, 0, 36'h0, 2'd0));
        tab_b.push_back(mk(0, 36'h0, 1, 1, 1, 36'h1, 2'd1));
        tab_b.push_back(mk(0, 36'h0, 1, 1, 1, 36'h2, 2'd1));
        tab_b.push_back(mk(0, 36'h0, 1, 0, 1, 36'h3, 2'd1));
        tab_b.push_back(mk(0, 36'h0, 1, 0, 1, 36'h4, 2'd1));
        tab_b.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));
        tab_b.push_back(mk(5, 36'h21, 0, 1, 0, 36'h0,  2'd0));
        tab_b.push_back(mk(0, 36'h0,  0, 1, 0, 36'h0,  2'd0));
        tab_b.push_back(mk(0, 36'h0,  0, 0, 1, 36'h21, 2'd1));
        tab_b.push_back(mk(0, 36'h0,  0, 0, 1, 36'h21, 2'd2));
        tab_b.push_back(mk(0, 36'h0,  0, 0, 1, 36'h21, 2'd2));
        tab_b.push_back(mk(0, 36'h0,  1, 1, 1, 36'h21, 2'd2));
        tab_b.push_back(mk(0, 36'h0,  1, 1, 1, 36'h22, 2'd1));
        tab_b.push_back(mk(0, 36'h0,  1, 1, 1, 36'h23, 2'd1));
        tab_b.push_back(mk(0, 36'h0,  1, 0, 1, 36'h24, 2'd1));
        tab_b.push_back(mk(0, 36'h0,  1, 0, 1, 36'h25, 2'd1));
        tab_b.push_back(mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0));
        tab_b.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));
        tab_b.push_back(mk(0, 36'h0, 0, 0, 0, 36'h0, 2'd0));
        tab_b.push_back(mk(0, 36'h0, 1, 0, 0, 36'h0, 2'd0));

        a_rst = 1'b1; b_rst = 1'b1;
        a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        a_rst = 1'b0; b_rst = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) step(0, tab_a[i], $sformatf("a%0d", i));
        for (int i = 0; i < tab_b.size(); i++) step(1, tab_b[i], $sformatf("b%0d", i));

        // Reset A while full with a read about to happen.
        step(0, mk(3, 36'h31, 0, 1, 0, 36'h0,  2'd0), "ra0");
        step(0, mk(0, 36'h0,  0, 1, 1, 36'h31, 2'd1), "ra1");
        a_ready = 1'b1;
        a_rst = 1'b1;
        #1;
        chk_zero(0, "mid_a");
        exp_x[0] = '0;
        @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        a_wr = a_rd;
        step(0, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pa0");
        step(0, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pa1");
        step(0, mk(1, 36'h41, 1, 1, 0, 36'h0,  2'd0), "pa2");
        step(0, mk(0, 36'h0,  1, 0, 1, 36'h41, 2'd1), "pa3");
        step(0, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pa4");

        // Reset B with one word held and one in flight from the FIFO.
        step(1, mk(3, 36'h51, 0, 1, 0, 36'h0, 2'd0), "rb0");
        step(1, mk(0, 36'h0,  0, 1, 0, 36'h0, 2'd0), "rb1");
        b_ready = 1'b1;
        b_rst = 1'b1;
        #1;
        chk_zero(1, "mid_b");
        exp_x[1] = '0;
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        b_wr = b_rd;
        step(1, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pb0");
        step(1, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pb1");
        step(1, mk(1, 36'h61, 1, 1, 0, 36'h0,  2'd0), "pb2");
        step(1, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pb3");
        step(1, mk(0, 36'h0,  1, 0, 1, 36'h61, 2'd1), "pb4");
        step(1, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "pb5");

`ifdef FIFO_READER_STREAM_XFER_CNT_EN
        // Preload the counter to all ones; one pop must wrap it to zero.
        force u_a.xfer_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release u_a.xfer_cnt_reg;
        exp_x[0] = 32'hFFFF_FFFF;
        step(0, mk(1, 36'h71, 1, 1, 0, 36'h0,  2'd0), "wr0");
        step(0, mk(0, 36'h0,  1, 0, 1, 36'h71, 2'd1), "wr1");
        step(0, mk(0, 36'h0,  1, 0, 0, 36'h0,  2'd0), "wr2");
`endif

        chk("final_xfer_a", 64'(a_xfer), 64'(exp_x[0]));
        chk("final_xfer_b", 64'(b_xfer), 64'(exp_x[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
